alu_exec_unit: RTL and testbench



---
 rtl/alu_pkg.sv | 48 ++++
 rtl/alu_comb_core.sv | 78 +++++++
 rtl/alu_exec_unit.sv | 208 ++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared types and constants for the execute-stage ALU.
//   alu_ctrl_e   : 4-bit ALUControl codes as produced by the decode stage.
//                  Branch compares reuse several arithmetic encodings, so those
//                  are exposed as typed aliases rather than extra enum members.
//   exec_state_e : IDLE / SHIFT / DONE sequencing of the execute unit.
//   shift_kind_e : shift flavour latched for the serial shifter.
// -----------------------------------------------------------------------------
package alu_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SUB  = 4'b0001,
      ALU_XOR  = 4'b0010,
      ALU_OR   = 4'b0011,
      ALU_AND  = 4'b0100,
      ALU_SLL  = 4'b0101,
      ALU_SRL  = 4'b0110,
      ALU_SRA  = 4'b0111,
      ALU_SLT  = 4'b1000,
      ALU_SLTU = 4'b1001,
      ALU_BEQ  = 4'b1010
   } alu_ctrl_e;

   // Branch compare codes that share an encoding with an arithmetic op;
   // which meaning applies is selected by the separate branch input.
   localparam alu_ctrl_e ALU_BNE  = ALU_XOR;
   localparam alu_ctrl_e ALU_BLT  = ALU_SRL;
   localparam alu_ctrl_e ALU_BGE  = ALU_SRA;
   localparam alu_ctrl_e ALU_BLTU = ALU_SLT;
   localparam alu_ctrl_e ALU_BGEU = ALU_SLTU;

   localparam logic [3:0] ALU_INVALID = 4'b1111;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } exec_state_e;

   typedef enum logic [1:0] {
      SH_SLL = 2'd0,
      SH_SRL = 2'd1,
      SH_SRA = 2'd2
   } shift_kind_e;

endpackage

// File: rtl/alu_comb_core.sv
// -----------------------------------------------------------------------------
// alu_comb_core
// Purely combinational single-cycle ALU operations and branch compares.
// Shift codes are not evaluated here; they are only flagged via is_shift so
// the execute unit can run them through its serial shifter.
// Ports:
//   alu_control  in  4   ALUControl code
//   branch       in  1   interpret code as branch compare
//   op_a, op_b   in  W   operands
//   result       out W   single-cycle result (a - b for branch compares)
//   branch_taken out 1   branch condition (branch codes only)
//   illegal      out 1   code not supported in the selected mode
//   is_shift     out 1   legal non-branch shift code
// -----------------------------------------------------------------------------
module alu_comb_core
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [3:0]            alu_control,
   input  logic                  branch,
   input  logic [DATA_WIDTH-1:0] op_a,
   input  logic [DATA_WIDTH-1:0] op_b,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  branch_taken,
   output logic                  illegal,
   output logic                  is_shift
);

   logic [DATA_WIDTH-1:0] diff;
   logic                  lt_s;
   logic                  lt_u;
   logic                  eq;

   assign diff = op_a - op_b;
   assign lt_s = $signed(op_a) < $signed(op_b);
   assign lt_u = op_a < op_b;
   assign eq   = (op_a == op_b);

   always_comb begin
      result       = '0;
      branch_taken = 1'b0;
      illegal      = 1'b0;
      is_shift     = 1'b0;
      if (branch) begin
         // Every legal compare also reports the difference on result.
         result = diff;
         case (alu_control)
            ALU_BEQ:  branch_taken = eq;
            ALU_BNE:  branch_taken = !eq;
            ALU_BLT:  branch_taken = lt_s;
            ALU_BGE:  branch_taken = !lt_s;
            ALU_BLTU: branch_taken = lt_u;
            ALU_BGEU: branch_taken = !lt_u;
            default: begin
               result  = '0;
               illegal = 1'b1;
            end
         endcase
      end else begin
         case (alu_control)
            ALU_ADD:  result = op_a + op_b;
            ALU_SUB:  result = diff;
            ALU_XOR:  result = op_a ^ op_b;
            ALU_OR:   result = op_a | op_b;
            ALU_AND:  result = op_a & op_b;
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:  is_shift = 1'b1;
            ALU_SLT:  result = {{(DATA_WIDTH-1){1'b0}}, lt_s};
            ALU_SLTU: result = {{(DATA_WIDTH-1){1'b0}}, lt_u};
            ALU_INVALID: illegal = 1'b1;
            default:     illegal = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
// Execute-stage ALU with valid/ready handshakes. Single-cycle ops register
// their result at acceptance; shifts go through a 1-bit-per-cycle shifter.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   in_valid/in_ready input handshake (ready only in IDLE)
//   alu_control       ALUControl code, branch selects compare meaning
//   op_a, op_b        operands, sampled only at acceptance
//   flush             kills any in-flight op, blocks acceptance that cycle
//   out_valid/out_ready output handshake
//   result, branch_taken, illegal  registered outputs, stable while DONE
//   busy              state != IDLE, for the hazard unit
// -----------------------------------------------------------------------------
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [3:0]            alu_control,
   input  logic                  branch,
   input  logic [DATA_WIDTH-1:0] op_a,
   input  logic [DATA_WIDTH-1:0] op_b,
   input  logic                  flush,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  branch_taken,
   output logic                  illegal,
   output logic                  busy
);

   exec_state_e            state_reg;
   exec_state_e            state_next;
   logic [DATA_WIDTH-1:0]  shreg_reg;
   logic [DATA_WIDTH-1:0]  result_reg;
   logic [SHAMT_WIDTH-1:0] cnt_reg;
   shift_kind_e            kind_reg;
   logic                   branch_taken_reg;
   logic                   illegal_reg;

   logic [DATA_WIDTH-1:0]  core_result;
   logic                   core_branch_taken;
   logic                   core_illegal;
   logic                   core_is_shift;

   logic [SHAMT_WIDTH-1:0] shamt;
   shift_kind_e            kind_dec;
   logic                   accept;
   logic                   last_shift;
   logic                   shift_fill;
   logic [DATA_WIDTH-1:0]  shift_one;

   alu_comb_core #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_core (
      .alu_control  (alu_control),
      .branch       (branch),
      .op_a         (op_a),
      .op_b         (op_b),
      .result       (core_result),
      .branch_taken (core_branch_taken),
      .illegal      (core_illegal),
      .is_shift     (core_is_shift)
   );

   assign shamt      = op_b[SHAMT_WIDTH-1:0];
   assign accept     = in_valid && (state_reg == IDLE) && !flush;
   assign last_shift = (cnt_reg == SHAMT_WIDTH'(1));

   always_comb begin
      case (alu_control[1:0])
         2'b01:   kind_dec = SH_SLL;
         2'b10:   kind_dec = SH_SRL;
         default: kind_dec = SH_SRA;
      endcase
   end

   // One-bit shift of the working register. Left shifts pull from the bit
   // below, right shifts from the bit above; the MSB fill is the sign for sra.
   assign shift_fill = (kind_reg == SH_SRA) ? shreg_reg[DATA_WIDTH-1] : 1'b0;

   generate
      for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_shift
         logic lo_bit;
         logic hi_bit;
         if (gi == 0) begin : g_lo_edge
            assign lo_bit = 1'b0;
         end else begin : g_lo_mid
            assign lo_bit = shreg_reg[gi-1];
         end
         if (gi == DATA_WIDTH-1) begin : g_hi_edge
            assign hi_bit = shift_fill;
         end else begin : g_hi_mid
            assign hi_bit = shreg_reg[gi+1];
         end
         assign shift_one[gi] = (kind_reg == SH_SLL) ? lo_bit : hi_bit;
      end
   endgenerate

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      if (flush) begin
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  if (core_is_shift && (shamt != '0)) begin
                     state_next = SHIFT;
                  end else begin
                     state_next = DONE;
                  end
               end
            end
            SHIFT: begin
               if (last_shift) begin
                  state_next = DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_next = IDLE;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // Output decode. out_valid is masked by flush so a killed result is never
   // handed downstream in the cycle the kill arrives.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      case (state_reg)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
         end
         DONE:    out_valid = !flush;
         default: ;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shreg_reg        <= '0;
         cnt_reg          <= '0;
         kind_reg         <= SH_SLL;
         result_reg       <= '0;
         branch_taken_reg <= 1'b0;
         illegal_reg      <= 1'b0;
      end else if (!flush) begin
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  if (core_is_shift) begin
                     branch_taken_reg <= 1'b0;
                     illegal_reg      <= 1'b0;
                     if (shamt == '0) begin
                        result_reg <= op_a;
                     end else begin
                        shreg_reg <= op_a;
                        cnt_reg   <= shamt;
                        kind_reg  <= kind_dec;
                     end
                  end else begin
                     result_reg       <= core_result;
                     branch_taken_reg <= core_branch_taken;
                     illegal_reg      <= core_illegal;
                  end
               end
            end
            SHIFT: begin
               shreg_reg <= shift_one;
               cnt_reg   <= cnt_reg - SHAMT_WIDTH'(1);
               if (last_shift) begin
                  result_reg <= shift_one;
               end
            end
            default: ;
         endcase
      end
   end

   assign result       = result_reg;
   assign branch_taken = branch_taken_reg;
   assign illegal      = illegal_reg;

endmodule

// File: tb/tb_alu_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_unit
// Self-checking bench for alu_exec_unit: directed scenarios plus randomized
// operations compared against a behavioural reference model.
// -----------------------------------------------------------------------------
module tb_alu_exec_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  alu_control;
   logic        branch;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        branch_taken;
   logic        illegal;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   alu_exec_unit #(
      .DATA_WIDTH (32)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .alu_control  (alu_control),
      .branch       (branch),
      .op_a         (op_a),
      .op_b         (op_b),
      .flush        (flush),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .result       (result),
      .branch_taken (branch_taken),
      .illegal      (illegal),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference model: expected outputs and the number of extra shifting
   // cycles between acceptance and out_valid.
   function automatic void ref_model(input logic [3:0] c, input logic br,
                                     input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] r, output logic t,
                                     output logic il, output int lat);
      int sh;
      sh  = int'(b[4:0]);
      r   = 32'd0;
      t   = 1'b0;
      il  = 1'b0;
      lat = 0;
      if (!br) begin
         case (c)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = a ^ b;
            4'd3: r = a | b;
            4'd4: r = a & b;
            4'd5: begin r = a << sh; lat = sh; end
            4'd6: begin r = a >> sh; lat = sh; end
            4'd7: begin r = $signed(a) >>> sh; lat = sh; end
            4'd8: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9: r = (a < b) ? 32'd1 : 32'd0;
            default: il = 1'b1;
         endcase
      end else begin
         r = a - b;
         case (c)
            4'd10: t = (a == b);
            4'd2:  t = (a != b);
            4'd6:  t = ($signed(a) < $signed(b));
            4'd7:  t = ($signed(a) >= $signed(b));
            4'd8:  t = (a < b);
            4'd9:  t = (a >= b);
            default: begin r = 32'd0; il = 1'b1; end
         endcase
      end
   endfunction

   // Issue one op, wait for its result, check against the model.
   task automatic run_op(input logic [3:0] c, input logic br,
                         input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] got);
      logic [31:0] exp_r;
      logic        exp_t;
      logic        exp_il;
      int          exp_lat;
      int          waited;
      ref_model(c, br, a, b, exp_r, exp_t, exp_il, exp_lat);
      got = 32'hx;
      @(negedge clk);
      waited = 0;
      while (!in_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if (!in_ready) begin
         failures++;
         $display("FAIL accept_timeout ctrl=%h br=%b in_ready=%b required 1", c, br, in_ready);
         return;
      end
      in_valid = 1'b1; alu_control = c; branch = br; op_a = a; op_b = b;
      @(posedge clk);
      #1;
      // Scramble inputs after acceptance; the unit must ignore them.
      in_valid = 1'b0; alu_control = 4'($urandom); branch = 1'($urandom);
      op_a = $urandom; op_b = $urandom;
      @(negedge clk);
      waited = 0;
      while (!out_valid && waited < 200) begin
         checks++;
         if (in_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL shift_busy ctrl=%h in_ready=%b busy=%b required 0/1", c, in_ready, busy);
         end
         @(negedge clk);
         waited++;
      end
      got = result;
      checks++;
      if (waited !== exp_lat) begin
         failures++;
         $display("FAIL latency ctrl=%h br=%b got=%0d required=%0d", c, br, waited, exp_lat);
      end
      checks++;
      if (result !== exp_r) begin
         failures++;
         $display("FAIL result ctrl=%h br=%b a=%h b=%h got=%h required=%h", c, br, a, b, result, exp_r);
      end
      checks++;
      if (branch_taken !== exp_t || illegal !== exp_il) begin
         failures++;
         $display("FAIL flags ctrl=%h br=%b bt=%b ill=%b required bt=%b ill=%b",
                  c, br, branch_taken, illegal, exp_t, exp_il);
      end
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL done_handshake ctrl=%h in_ready=%b busy=%b required 0/1", c, in_ready, busy);
      end
      $display("op ctrl=%h br=%b a=%h b=%h -> result=%h bt=%b ill=%b lat=%0d",
               c, br, a, b, result, branch_taken, illegal, waited);
   endtask

   task automatic test_reset;
      rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      alu_control = 4'd0; branch = 1'b0; op_a = 32'd0; op_b = 32'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || result !== 32'd0 || branch_taken !== 1'b0 ||
          illegal !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_state ov=%b res=%h bt=%b ill=%b busy=%b rdy=%b required 0/0/0/0/0/1",
                  out_valid, result, branch_taken, illegal, busy, in_ready);
      end
      rst_n = 1'b1;
      $display("reset done");
   endtask

   task automatic test_directed_ops;
      logic [31:0] got;
      run_op(4'b0000, 1'b0, 32'd5, 32'd7, got);
      checks++;
      if (got !== 32'd12) begin
         failures++;
         $display("FAIL add_5_7 got=%h required=%h", got, 32'd12);
      end
      run_op(4'b0111, 1'b0, 32'h8000_0000, 32'd4, got);
      checks++;
      if (got !== 32'hF800_0000) begin
         failures++;
         $display("FAIL sra_by_4 got=%h required=%h", got, 32'hF800_0000);
      end
      run_op(4'b0101, 1'b0, 32'h1234_5678, 32'd0, got);
      checks++;
      if (got !== 32'h1234_5678) begin
         failures++;
         $display("FAIL sll_by_0 got=%h required=%h", got, 32'h1234_5678);
      end
      run_op(4'b0110, 1'b0, 32'h8000_0000, 32'd31, got);
   endtask

   task automatic test_branch;
      logic [31:0] got;
      run_op(4'b0110, 1'b1, 32'hFFFF_FFFF, 32'd1, got);
      checks++;
      if (branch_taken !== 1'b1) begin
         failures++;
         $display("FAIL blt_neg got=%b required=1", branch_taken);
      end
      run_op(4'b1000, 1'b1, 32'hFFFF_FFFF, 32'd1, got);
      checks++;
      if (branch_taken !== 1'b0) begin
         failures++;
         $display("FAIL bltu_big got=%b required=0", branch_taken);
      end
      run_op(4'b1010, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, got);
      checks++;
      if (branch_taken !== 1'b1) begin
         failures++;
         $display("FAIL beq_equal got=%b required=1", branch_taken);
      end
      run_op(4'b0111, 1'b1, 32'd3, 32'd3, got);
      run_op(4'b1001, 1'b1, 32'd2, 32'd9, got);
   endtask

   task automatic test_illegal;
      logic [31:0] got;
      run_op(4'b1111, 1'b0, 32'hAAAA_0001, 32'h0000_0003, got);
      checks++;
      if (illegal !== 1'b1 || got !== 32'd0) begin
         failures++;
         $display("FAIL illegal_1111 ill=%b res=%h required 1/0", illegal, got);
      end
      run_op(4'b0011, 1'b1, 32'd10, 32'd10, got);
      checks++;
      if (illegal !== 1'b1 || branch_taken !== 1'b0) begin
         failures++;
         $display("FAIL illegal_br_0011 ill=%b bt=%b required 1/0", illegal, branch_taken);
      end
      run_op(4'b0000, 1'b0, 32'd1, 32'd1, got);
      checks++;
      if (illegal !== 1'b0) begin
         failures++;
         $display("FAIL illegal_clear ill=%b required 0", illegal);
      end
   endtask

   task automatic test_backpressure;
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom; b = $urandom;
      @(negedge clk);
      out_ready = 1'b0;
      in_valid = 1'b1; alu_control = 4'b0000; branch = 1'b0; op_a = a; op_b = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0; op_a = $urandom; op_b = $urandom;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || result !== a + b || in_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL backpressure_hold cyc=%0d ov=%b res=%h rdy=%b busy=%b required 1/%h/0/1",
                     i, out_valid, result, in_ready, busy, a + b);
         end
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL backpressure_release ov=%b rdy=%b busy=%b required 0/1/0",
                  out_valid, in_ready, busy);
      end
      $display("backpressure add a=%h b=%h held result=%h", a, b, a + b);
   endtask

   // Starts an sll by 20 and returns at the negedge of the 5th SHIFT cycle.
   task automatic start_long_shift(output int saw_valid);
      saw_valid = 0;
      @(negedge clk);
      in_valid = 1'b1; alu_control = 4'b0101; branch = 1'b0;
      op_a = $urandom | 32'h1; op_b = 32'd20;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (out_valid) saw_valid++;
      end
   endtask

   task automatic test_flush;
      int saw_valid;
      start_long_shift(saw_valid);
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
         failures++;
         $display("FAIL flush_pre_busy busy=%b rdy=%b required 1/0", busy, in_ready);
      end
      // Flush together with a new offer; the offer must not be taken.
      flush = 1'b1;
      in_valid = 1'b1; alu_control = 4'b0000; branch = 1'b0; op_a = 32'd1; op_b = 32'd2;
      @(posedge clk);
      #1;
      flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL flush_idle rdy=%b busy=%b ov=%b required 1/0/0", in_ready, busy, out_valid);
      end
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (out_valid) saw_valid++;
      end
      checks++;
      if (saw_valid !== 0) begin
         failures++;
         $display("FAIL flush_no_valid got=%0d valid cycles required=0", saw_valid);
      end
      $display("flush sll by 20 at shift cycle 5");
   endtask

   task automatic test_reset_mid_shift;
      logic [31:0] got;
      int          saw_valid;
      // Leave non-zero result and branch_taken behind so the reset is visible.
      run_op(4'b0010, 1'b1, 32'd9, 32'd3, got);
      start_long_shift(saw_valid);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || result !== 32'd0 || branch_taken !== 1'b0 ||
          illegal !== 1'b0 || busy !== 1'b0 || saw_valid !== 0) begin
         failures++;
         $display("FAIL reset_mid_shift ov=%b res=%h bt=%b ill=%b busy=%b required all 0",
                  out_valid, result, branch_taken, illegal, busy);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (out_valid) saw_valid++;
      end
      checks++;
      if (saw_valid !== 0) begin
         failures++;
         $display("FAIL reset_no_valid got=%0d required=0", saw_valid);
      end
      $display("reset during sll by 20");
   endtask

   task automatic test_back_to_back;
      int nvalid;
      int bad;
      nvalid = 0; bad = 0;
      @(negedge clk);
      in_valid = 1'b1; alu_control = 4'b0000; branch = 1'b0; op_a = 32'd100; op_b = 32'd1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_valid) begin
            nvalid++;
            if (result !== 32'd101 || in_ready !== 1'b0) bad++;
         end
      end
      in_valid = 1'b0;
      checks++;
      if (nvalid !== 5 || bad !== 0) begin
         failures++;
         $display("FAIL back_to_back results=%0d bad=%0d required 5/0", nvalid, bad);
      end
      $display("back_to_back adds in 10 cycles: %0d results", nvalid);
   endtask

   task automatic test_random;
      logic [31:0] got;
      logic [3:0]  c;
      logic        br;
      logic [31:0] a;
      logic [31:0] b;
      for (int n = 0; n < 80; n++) begin
         c  = 4'($urandom_range(0, 15));
         br = 1'($urandom_range(0, 1));
         a  = $urandom;
         b  = $urandom;
         if ($urandom_range(0, 3) == 0) b = a;
         if ($urandom_range(0, 3) == 0) a = {1'b1, a[30:0]};
         run_op(c, br, a, b, got);
      end
   endtask

   initial begin
      test_reset();
      test_directed_ops();
      test_branch();
      test_illegal();
      test_backpressure();
      test_flush();
      test_reset_mid_shift();
      test_back_to_back();
      test_random();
      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
